// File: rtl/map_table_recover_if.sv
// Bundle of the rename-map ports: dispatch lookups and writes, completion
// broadcasts, retirement writes and the flush request.
interface map_table_recover_if #(
    parameter int DISPATCH_WIDTH = 2,
    parameter int CDB_WIDTH      = 4,
    parameter int COMMIT_WIDTH   = 2,
    parameter int AR_BITS        = 5,
    parameter int PR_BITS        = 7
);
    logic [DISPATCH_WIDTH-1:0]         disp_valid;
    logic [DISPATCH_WIDTH*AR_BITS-1:0] disp_dest_ar;
    logic [DISPATCH_WIDTH*PR_BITS-1:0] disp_dest_pr;
    logic [DISPATCH_WIDTH*AR_BITS-1:0] disp_src_a_ar;
    logic [DISPATCH_WIDTH*AR_BITS-1:0] disp_src_b_ar;
    logic [DISPATCH_WIDTH*PR_BITS-1:0] src_a_pr;
    logic [DISPATCH_WIDTH*PR_BITS-1:0] src_b_pr;
    logic [DISPATCH_WIDTH-1:0]         src_a_ready;
    logic [DISPATCH_WIDTH-1:0]         src_b_ready;
    logic [DISPATCH_WIDTH*PR_BITS-1:0] told_pr;
    logic [CDB_WIDTH-1:0]              cdb_valid;
    logic [CDB_WIDTH*AR_BITS-1:0]      cdb_ar_tag;
    logic [CDB_WIDTH*PR_BITS-1:0]      cdb_pr_tag;
    logic [COMMIT_WIDTH-1:0]           commit_valid;
    logic [COMMIT_WIDTH*AR_BITS-1:0]   commit_ar;
    logic [COMMIT_WIDTH*PR_BITS-1:0]   commit_pr;
    logic                              recover;

    modport master (
        output disp_valid, disp_dest_ar, disp_dest_pr, disp_src_a_ar, disp_src_b_ar,
        output cdb_valid, cdb_ar_tag, cdb_pr_tag,
        output commit_valid, commit_ar, commit_pr, recover,
        input  src_a_pr, src_b_pr, src_a_ready, src_b_ready, told_pr
    );

    modport slave (
        input  disp_valid, disp_dest_ar, disp_dest_pr, disp_src_a_ar, disp_src_b_ar,
        input  cdb_valid, cdb_ar_tag, cdb_pr_tag,
        input  commit_valid, commit_ar, commit_pr, recover,
        output src_a_pr, src_b_pr, src_a_ready, src_b_ready, told_pr
    );
endinterface

// File: rtl/map_table_recover.sv
// Register rename map with a speculative table (PR + ready per AR) and an
// architectural table (PR per AR). Flush copies the architectural table,
// including same-cycle commits, back into the speculative table.
module map_table_recover #(
    parameter int DISPATCH_WIDTH = 2,
    parameter int CDB_WIDTH      = 4,
    parameter int COMMIT_WIDTH   = 2,
    parameter int AR_BITS        = 5,
    parameter int PR_BITS        = 7
) (
    input  logic               clk,
    input  logic               rst,
    map_table_recover_if.slave bus
);
    localparam int                 NUM_AR  = 1 << AR_BITS;
    localparam logic [AR_BITS-1:0] ZERO_AR = AR_BITS'(NUM_AR - 1);
    localparam logic [PR_BITS-1:0] ZERO_PR = PR_BITS'(NUM_AR - 1);

    logic [PR_BITS-1:0] spec_pr_reg  [NUM_AR];
    logic [PR_BITS-1:0] spec_pr_next [NUM_AR];
    logic [NUM_AR-1:0]  spec_rdy_reg;
    logic [NUM_AR-1:0]  spec_rdy_next;
    logic [PR_BITS-1:0] arch_pr_reg  [NUM_AR];
    logic [PR_BITS-1:0] arch_pr_next [NUM_AR];

    // Next state: commits first (needed by flush), then either flush or CDB + dispatch.
    always_comb begin
        arch_pr_next  = arch_pr_reg;
        spec_pr_next  = spec_pr_reg;
        spec_rdy_next = spec_rdy_reg;
        // Ascending slot order lets the youngest slot win an AR conflict.
        for (int m = 0; m < COMMIT_WIDTH; m++) begin
            if (bus.commit_valid[m] && bus.commit_ar[m*AR_BITS +: AR_BITS] != ZERO_AR)
                arch_pr_next[bus.commit_ar[m*AR_BITS +: AR_BITS]] = bus.commit_pr[m*PR_BITS +: PR_BITS];
        end
        if (bus.recover) begin
            spec_pr_next  = arch_pr_next;
            spec_rdy_next = '1;
        end else begin
            // Completion only marks ready if the tag still matches the current mapping.
            for (int c = 0; c < CDB_WIDTH; c++) begin
                if (bus.cdb_valid[c] &&
                    spec_pr_reg[bus.cdb_ar_tag[c*AR_BITS +: AR_BITS]] == bus.cdb_pr_tag[c*PR_BITS +: PR_BITS])
                    spec_rdy_next[bus.cdb_ar_tag[c*AR_BITS +: AR_BITS]] = 1'b1;
            end
            // Dispatch overrides a same-cycle completion on the same AR.
            for (int d = 0; d < DISPATCH_WIDTH; d++) begin
                if (bus.disp_valid[d] && bus.disp_dest_ar[d*AR_BITS +: AR_BITS] != ZERO_AR) begin
                    spec_pr_next[bus.disp_dest_ar[d*AR_BITS +: AR_BITS]]  = bus.disp_dest_pr[d*PR_BITS +: PR_BITS];
                    spec_rdy_next[bus.disp_dest_ar[d*AR_BITS +: AR_BITS]] = 1'b0;
                end
            end
        end
    end

    // Table state; reset forces identity mapping with everything ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_AR; i++) begin
                spec_pr_reg[i] <= PR_BITS'(i);
                arch_pr_reg[i] <= PR_BITS'(i);
            end
            spec_rdy_reg <= '1;
        end else begin
            spec_pr_reg  <= spec_pr_next;
            spec_rdy_reg <= spec_rdy_next;
            arch_pr_reg  <= arch_pr_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DISPATCH_WIDTH; gi++) begin : g_slot
            logic [AR_BITS-1:0] src_a;
            logic [AR_BITS-1:0] src_b;
            logic [AR_BITS-1:0] dest;
            logic [PR_BITS-1:0] a_pr;
            logic [PR_BITS-1:0] b_pr;
            logic [PR_BITS-1:0] t_pr;
            logic               a_rdy;
            logic               b_rdy;

            // Lookup: map entry (ready if stored or broadcast now), then bypass from
            // older slots in the group, then the hardwired zero register.
            always_comb begin
                src_a = bus.disp_src_a_ar[gi*AR_BITS +: AR_BITS];
                src_b = bus.disp_src_b_ar[gi*AR_BITS +: AR_BITS];
                dest  = bus.disp_dest_ar[gi*AR_BITS +: AR_BITS];
                a_pr  = spec_pr_reg[src_a];
                b_pr  = spec_pr_reg[src_b];
                t_pr  = spec_pr_reg[dest];
                a_rdy = spec_rdy_reg[src_a];
                b_rdy = spec_rdy_reg[src_b];
                for (int c = 0; c < CDB_WIDTH; c++) begin
                    if (bus.cdb_valid[c] && bus.cdb_pr_tag[c*PR_BITS +: PR_BITS] == a_pr) a_rdy = 1'b1;
                    if (bus.cdb_valid[c] && bus.cdb_pr_tag[c*PR_BITS +: PR_BITS] == b_pr) b_rdy = 1'b1;
                end
                for (int k = 0; k < gi; k++) begin
                    if (bus.disp_valid[k] && bus.disp_dest_ar[k*AR_BITS +: AR_BITS] == src_a) begin
                        a_pr  = bus.disp_dest_pr[k*PR_BITS +: PR_BITS];
                        a_rdy = 1'b0;
                    end
                    if (bus.disp_valid[k] && bus.disp_dest_ar[k*AR_BITS +: AR_BITS] == src_b) begin
                        b_pr  = bus.disp_dest_pr[k*PR_BITS +: PR_BITS];
                        b_rdy = 1'b0;
                    end
                    if (bus.disp_valid[k] && bus.disp_dest_ar[k*AR_BITS +: AR_BITS] == dest)
                        t_pr = bus.disp_dest_pr[k*PR_BITS +: PR_BITS];
                end
                if (src_a == ZERO_AR) begin
                    a_pr  = ZERO_PR;
                    a_rdy = 1'b1;
                end
                if (src_b == ZERO_AR) begin
                    b_pr  = ZERO_PR;
                    b_rdy = 1'b1;
                end
                if (dest == ZERO_AR) t_pr = ZERO_PR;
            end

            assign bus.src_a_pr[gi*PR_BITS +: PR_BITS] = a_pr;
            assign bus.src_b_pr[gi*PR_BITS +: PR_BITS] = b_pr;
            assign bus.told_pr[gi*PR_BITS +: PR_BITS]  = t_pr;
            assign bus.src_a_ready[gi]                 = a_rdy;
            assign bus.src_b_ready[gi]                 = b_rdy;
        end
    endgenerate
endmodule

// File: tb/tb_map_table_recover.sv
// Bench for map_table_recover: directed scenarios plus randomized traffic
// checked against a sequential-rename reference model.
module tb_map_table_recover;
    localparam int DW = 2, CW = 4, MW = 2, AB = 5, PB = 7;
    localparam int NAR = 32, ZR = 31;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    map_table_recover_if #(.DISPATCH_WIDTH(DW), .CDB_WIDTH(CW), .COMMIT_WIDTH(MW),
                           .AR_BITS(AB), .PR_BITS(PB)) bus();
    map_table_recover #(.DISPATCH_WIDTH(DW), .CDB_WIDTH(CW), .COMMIT_WIDTH(MW),
                        .AR_BITS(AB), .PR_BITS(PB)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Stimulus tables
    bit d_v[DW]; int d_dst[DW]; int d_pr[DW]; int d_a[DW]; int d_b[DW];
    bit c_v[CW]; int c_ar[CW]; int c_pr[CW];
    bit k_v[MW]; int k_ar[MW]; int k_pr[MW];
    bit rcv;

    // Reference model state and expectations
    int m_spec[NAR]; bit m_rdy[NAR]; int m_arch[NAR];
    int e_a_pr[DW]; bit e_a_rdy[DW]; int e_b_pr[DW]; bit e_b_rdy[DW]; int e_told[DW];

    int tests = 0;
    int fails = 0;

    always_comb begin
        for (int i = 0; i < DW; i++) begin
            bus.disp_valid[i]               = d_v[i];
            bus.disp_dest_ar[i*AB +: AB]    = AB'(d_dst[i]);
            bus.disp_dest_pr[i*PB +: PB]    = PB'(d_pr[i]);
            bus.disp_src_a_ar[i*AB +: AB]   = AB'(d_a[i]);
            bus.disp_src_b_ar[i*AB +: AB]   = AB'(d_b[i]);
        end
        for (int i = 0; i < CW; i++) begin
            bus.cdb_valid[i]             = c_v[i];
            bus.cdb_ar_tag[i*AB +: AB]   = AB'(c_ar[i]);
            bus.cdb_pr_tag[i*PB +: PB]   = PB'(c_pr[i]);
        end
        for (int i = 0; i < MW; i++) begin
            bus.commit_valid[i]          = k_v[i];
            bus.commit_ar[i*AB +: AB]    = AB'(k_ar[i]);
            bus.commit_pr[i*PB +: PB]    = PB'(k_pr[i]);
        end
        bus.recover = rcv;
    end

    task automatic clear_inputs();
        for (int i = 0; i < DW; i++) begin d_v[i] = 0; d_dst[i] = ZR; d_pr[i] = 0; d_a[i] = 0; d_b[i] = 0; end
        for (int i = 0; i < CW; i++) begin c_v[i] = 0; c_ar[i] = 0; c_pr[i] = 0; end
        for (int i = 0; i < MW; i++) begin k_v[i] = 0; k_ar[i] = 0; k_pr[i] = 0; end
        rcv = 0;
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NAR; i++) begin m_spec[i] = i; m_rdy[i] = 1; m_arch[i] = i; end
    endfunction

    function automatic bit cdb_has(int pr);
        for (int c = 0; c < CW; c++) if (c_v[c] && c_pr[c] == pr) return 1;
        return 0;
    endfunction

    // Rename the group one instruction at a time against a scratch copy of the map.
    function automatic void model_lookup();
        int  cp[NAR];
        bit  byp[NAR];
        cp = m_spec;
        for (int i = 0; i < NAR; i++) byp[i] = 0;
        for (int j = 0; j < DW; j++) begin
            e_a_pr[j]  = cp[d_a[j]];
            e_a_rdy[j] = byp[d_a[j]] ? 1'b0 : (m_rdy[d_a[j]] || cdb_has(cp[d_a[j]]));
            e_b_pr[j]  = cp[d_b[j]];
            e_b_rdy[j] = byp[d_b[j]] ? 1'b0 : (m_rdy[d_b[j]] || cdb_has(cp[d_b[j]]));
            e_told[j]  = cp[d_dst[j]];
            if (d_v[j] && d_dst[j] != ZR) begin
                cp[d_dst[j]]  = d_pr[j];
                byp[d_dst[j]] = 1;
            end
        end
    endfunction

    function automatic void model_clock();
        bit new_rdy[NAR];
        for (int m = 0; m < MW; m++) if (k_v[m] && k_ar[m] != ZR) m_arch[k_ar[m]] = k_pr[m];
        if (rcv) begin
            for (int i = 0; i < NAR; i++) begin m_spec[i] = m_arch[i]; m_rdy[i] = 1; end
        end else begin
            new_rdy = m_rdy;
            for (int c = 0; c < CW; c++) if (c_v[c] && m_spec[c_ar[c]] == c_pr[c]) new_rdy[c_ar[c]] = 1;
            m_rdy = new_rdy;
            for (int d = 0; d < DW; d++)
                if (d_v[d] && d_dst[d] != ZR) begin m_spec[d_dst[d]] = d_pr[d]; m_rdy[d_dst[d]] = 0; end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    // Read the current mapping of one AR through slot 0 without writing anything.
    task automatic peek(input int ar, output int pr, output bit rdy);
        clear_inputs();
        d_v[0] = 1; d_a[0] = ar; d_dst[0] = ZR;
        #1;
        pr  = int'(bus.src_a_pr[PB-1:0]);
        rdy = bus.src_a_ready[0];
        clear_inputs();
    endtask

    task automatic test_reset();
        int pr; bit rdy;
        clear_inputs();
        rst = 1;
        model_reset();
        #12;
        for (int ar = 0; ar < NAR; ar++) begin
            peek(ar, pr, rdy);
            tests++;
            if (pr !== ar || rdy !== 1'b1) begin
                fails++;
                $display("FAIL reset_map ar%0d: got pr %0d rdy %0d, want pr %0d rdy 1", ar, pr, rdy, ar);
            end
        end
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        $display("[TB] test_reset done");
    endtask

    task automatic test_lookup_basic();
        clear_inputs();
        d_v[0] = 1; d_a[0] = 3; d_b[0] = ZR; d_dst[0] = 3; d_pr[0] = 10;
        #1;
        tests++;
        if (bus.src_a_pr[PB-1:0] !== 7'd3 || bus.src_a_ready[0] !== 1'b1 || bus.told_pr[PB-1:0] !== 7'd3) begin
            fails++;
            $display("FAIL basic_lookup: got a_pr %0d rdy %0d told %0d, want 3 1 3",
                     bus.src_a_pr[PB-1:0], bus.src_a_ready[0], bus.told_pr[PB-1:0]);
        end
        tests++;
        if (bus.src_b_pr[PB-1:0] !== 7'd31 || bus.src_b_ready[0] !== 1'b1) begin
            fails++;
            $display("FAIL zero_reg_lookup: got %0d rdy %0d, want 31 1", bus.src_b_pr[PB-1:0], bus.src_b_ready[0]);
        end
        clear_inputs();
        $display("[TB] test_lookup_basic done");
    endtask

    task automatic test_bypass();
        int pr; bit rdy;
        clear_inputs();
        d_v[0] = 1; d_dst[0] = 4; d_pr[0] = 40;
        d_v[1] = 1; d_a[1] = 4; d_dst[1] = 4; d_pr[1] = 41;
        #1;
        tests++;
        if (bus.src_a_pr[2*PB-1:PB] !== 7'd40 || bus.src_a_ready[1] !== 1'b0 || bus.told_pr[2*PB-1:PB] !== 7'd40) begin
            fails++;
            $display("FAIL intra_bypass: got a_pr %0d rdy %0d told %0d, want 40 0 40",
                     bus.src_a_pr[2*PB-1:PB], bus.src_a_ready[1], bus.told_pr[2*PB-1:PB]);
        end
        step();
        peek(4, pr, rdy);
        tests++;
        if (pr !== 41 || rdy !== 1'b0) begin
            fails++;
            $display("FAIL youngest_write: got %0d rdy %0d, want 41 0", pr, rdy);
        end
        $display("[TB] test_bypass done");
    endtask

    task automatic test_cdb();
        int pr; bit rdy;
        clear_inputs();
        c_v[2] = 1; c_ar[2] = 4; c_pr[2] = 41;
        d_v[0] = 1; d_a[0] = 4; d_dst[0] = ZR;
        #1;
        tests++;
        if (bus.src_a_ready[0] !== 1'b1) begin
            fails++;
            $display("FAIL cdb_same_cycle: got rdy %0d, want 1", bus.src_a_ready[0]);
        end
        step();
        peek(4, pr, rdy);
        tests++;
        if (pr !== 41 || rdy !== 1'b1) begin
            fails++;
            $display("FAIL cdb_stored: got %0d rdy %0d, want 41 1", pr, rdy);
        end
        // Re-map AR 4, then broadcast a stale tag for it.
        d_v[0] = 1; d_dst[0] = 4; d_pr[0] = 41;
        step();
        clear_inputs();
        c_v[2] = 1; c_ar[2] = 4; c_pr[2] = 40;
        d_v[0] = 1; d_a[0] = 4; d_dst[0] = ZR;
        #1;
        tests++;
        if (bus.src_a_ready[0] !== 1'b0) begin
            fails++;
            $display("FAIL cdb_stale_same_cycle: got rdy %0d, want 0", bus.src_a_ready[0]);
        end
        step();
        peek(4, pr, rdy);
        tests++;
        if (pr !== 41 || rdy !== 1'b0) begin
            fails++;
            $display("FAIL cdb_stale_ignored: got %0d rdy %0d, want 41 0", pr, rdy);
        end
        // Dispatch wins over a same-cycle completion on the same AR.
        d_v[0] = 1; d_dst[0] = 5; d_pr[0] = 50;
        c_v[0] = 1; c_ar[0] = 5; c_pr[0] = 5;
        step();
        peek(5, pr, rdy);
        tests++;
        if (pr !== 50 || rdy !== 1'b0) begin
            fails++;
            $display("FAIL dispatch_over_cdb: got %0d rdy %0d, want 50 0", pr, rdy);
        end
        $display("[TB] test_cdb done");
    endtask

    task automatic test_recover();
        int pr; bit rdy;
        clear_inputs();
        k_v[0] = 1; k_ar[0] = 6; k_pr[0] = 60;
        step();
        clear_inputs();
        d_v[0] = 1; d_dst[0] = 6; d_pr[0] = 70;
        d_v[1] = 1; d_dst[1] = 7; d_pr[1] = 71;
        step();
        peek(6, pr, rdy);
        tests++;
        if (pr !== 70 || rdy !== 1'b0) begin
            fails++;
            $display("FAIL spec_before_recover: got %0d rdy %0d, want 70 0", pr, rdy);
        end
        rcv = 1; k_v[0] = 1; k_ar[0] = 7; k_pr[0] = 72;
        d_v[0] = 1; d_dst[0] = 8; d_pr[0] = 88;
        step();
        peek(6, pr, rdy);
        tests++;
        if (pr !== 60 || rdy !== 1'b1) begin
            fails++;
            $display("FAIL recover_ar6: got %0d rdy %0d, want 60 1", pr, rdy);
        end
        peek(7, pr, rdy);
        tests++;
        if (pr !== 72 || rdy !== 1'b1) begin
            fails++;
            $display("FAIL recover_ar7: got %0d rdy %0d, want 72 1", pr, rdy);
        end
        peek(8, pr, rdy);
        tests++;
        if (pr !== 8 || rdy !== 1'b1) begin
            fails++;
            $display("FAIL recover_drops_dispatch: got %0d rdy %0d, want 8 1", pr, rdy);
        end
        $display("[TB] test_recover done");
    endtask

    task automatic test_back_to_back();
        int pr; bit rdy;
        clear_inputs();
        rcv = 1; k_v[1] = 1; k_ar[1] = 9; k_pr[1] = 80;
        step();
        clear_inputs();
        rcv = 1; k_v[0] = 1; k_ar[0] = 9; k_pr[0] = 81;
        step();
        peek(9, pr, rdy);
        tests++;
        if (pr !== 81 || rdy !== 1'b1) begin
            fails++;
            $display("FAIL back_to_back_recover: got %0d rdy %0d, want 81 1", pr, rdy);
        end
        $display("[TB] test_back_to_back done");
    endtask

    task automatic test_zero_reg();
        int pr; bit rdy;
        clear_inputs();
        d_v[0] = 1; d_dst[0] = ZR; d_pr[0] = 99;
        k_v[0] = 1; k_ar[0] = ZR; k_pr[0] = 98;
        step();
        clear_inputs();
        rcv = 1;
        step();
        peek(ZR, pr, rdy);
        tests++;
        if (pr !== ZR || rdy !== 1'b1) begin
            fails++;
            $display("FAIL zero_reg_write: got %0d rdy %0d, want 31 1", pr, rdy);
        end
        $display("[TB] test_zero_reg done");
    endtask

    task automatic test_reset_mid();
        int pr; bit rdy;
        clear_inputs();
        d_v[0] = 1; d_dst[0] = 10; d_pr[0] = 100;
        step();
        clear_inputs();
        rcv = 1; k_v[0] = 1; k_ar[0] = 11; k_pr[0] = 111;
        #2;
        rst = 1;
        model_reset();
        #1;
        for (int i = 0; i < 4; i++) begin
            int ar;
            ar = (i == 0) ? 4 : (i == 1) ? 6 : (i == 2) ? 9 : 10;
            peek(ar, pr, rdy);
            tests++;
            if (pr !== ar || rdy !== 1'b1) begin
                fails++;
                $display("FAIL reset_mid ar%0d: got %0d rdy %0d, want %0d 1", ar, pr, rdy, ar);
            end
        end
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        $display("[TB] test_reset_mid done");
    endtask

    task automatic test_random();
        int bad;
        for (int n = 0; n < 400; n++) begin
            clear_inputs();
            for (int i = 0; i < DW; i++) begin
                d_v[i]   = ($urandom_range(3) != 0);
                d_dst[i] = $urandom_range(7) == 0 ? ZR : $urandom_range(7);
                d_pr[i]  = $urandom_range(127);
                d_a[i]   = $urandom_range(9) == 0 ? ZR : $urandom_range(7);
                d_b[i]   = $urandom_range(7);
            end
            for (int c = 0; c < CW; c++) begin
                c_v[c]  = ($urandom_range(1) != 0);
                c_ar[c] = $urandom_range(7);
                c_pr[c] = $urandom_range(2) != 0 ? m_spec[c_ar[c]] : $urandom_range(127);
            end
            for (int m = 0; m < MW; m++) begin
                k_v[m]  = ($urandom_range(2) == 0);
                k_ar[m] = $urandom_range(7);
                k_pr[m] = $urandom_range(127);
            end
            rcv = ($urandom_range(15) == 0);
            #1;
            model_lookup();
            bad = 0;
            for (int j = 0; j < DW; j++) begin
                if (d_v[j]) begin
                    tests++;
                    if (int'(bus.src_a_pr[j*PB +: PB]) !== e_a_pr[j] || bus.src_a_ready[j] !== e_a_rdy[j] ||
                        int'(bus.src_b_pr[j*PB +: PB]) !== e_b_pr[j] || bus.src_b_ready[j] !== e_b_rdy[j] ||
                        int'(bus.told_pr[j*PB +: PB]) !== e_told[j]) begin
                        fails++;
                        bad = 1;
                        $display("FAIL random_lookup cyc%0d slot%0d: got a %0d/%0d b %0d/%0d told %0d, want a %0d/%0d b %0d/%0d told %0d",
                                 n, j, bus.src_a_pr[j*PB +: PB], bus.src_a_ready[j], bus.src_b_pr[j*PB +: PB],
                                 bus.src_b_ready[j], bus.told_pr[j*PB +: PB], e_a_pr[j], e_a_rdy[j],
                                 e_b_pr[j], e_b_rdy[j], e_told[j]);
                    end
                end
            end
            $display("[TB] random cyc%0d disp %0d%0d rcv %0d %s", n, d_v[0], d_v[1], rcv, bad ? "bad" : "ok");
            step();
        end
    endtask

    initial begin
        clear_inputs();
        rst = 1;
        test_reset();
        test_lookup_basic();
        test_bypass();
        test_cdb();
        test_recover();
        test_back_to_back();
        test_zero_reg();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/map_table_recover.md
MAP_TABLE_RECOVER -- requirements
Module: map_table_recover

Interface
REQ-001 Parameter DISPATCH_WIDTH, default 2: rename slots per cycle (1..4).
REQ-002 Parameter CDB_WIDTH, default 4: completion broadcast channels per cycle (1..8).
REQ-003 Parameter COMMIT_WIDTH, default 2: retirement slots per cycle (1..4).
REQ-004 Parameter AR_BITS, default 5: architectural tag width; table depth 2**AR_BITS.
REQ-005 Parameter PR_BITS, default 7: physical tag width; PR_BITS SHALL be at least AR_BITS.
REQ-006 clock  in  1  sole clock, all state updates on rising edge.
REQ-007 reset  in  1  asynchronous, active-high.
REQ-008 disp_valid  in  DISPATCH_WIDTH  slot i carries a renamed instruction; slot 0 is oldest.
REQ-009 disp_dest_ar  in  DISPATCH_WIDTH*AR_BITS  destination AR per slot.
REQ-010 disp_dest_pr  in  DISPATCH_WIDTH*PR_BITS  new PR from the free list per slot.
REQ-011 disp_src_a_ar, disp_src_b_ar  in  DISPATCH_WIDTH*AR_BITS each  source ARs per slot.
REQ-012 src_a_pr, src_b_pr  out  DISPATCH_WIDTH*PR_BITS each  renamed source PRs.
REQ-013 src_a_ready, src_b_ready  out  DISPATCH_WIDTH each  source value available.
REQ-014 told_pr  out  DISPATCH_WIDTH*PR_BITS  previous mapping of the destination AR, for the ROB.
REQ-015 cdb_valid  in  CDB_WIDTH; cdb_ar_tag  in  CDB_WIDTH*AR_BITS; cdb_pr_tag  in  CDB_WIDTH*PR_BITS  completion broadcasts.
REQ-016 commit_valid  in  COMMIT_WIDTH; commit_ar  in  COMMIT_WIDTH*AR_BITS; commit_pr  in  COMMIT_WIDTH*PR_BITS  retiring mappings, slot 0 oldest.
REQ-017 recover  in  1  mispredict/exception flush request.

Function
REQ-018 Block SHALL hold a speculative map (PR + ready bit per AR) and an architectural map (PR per AR).
REQ-019 Lookups SHALL be combinational from current state plus same-cycle bypasses; outputs for a slot are don't-care when disp_valid is low.
REQ-020 Source lookup for slot j SHALL return disp_dest_pr of the youngest slot i<j with disp_valid and matching dest AR, with ready 0; otherwise the speculative map entry.
REQ-021 told_pr for slot j SHALL use the same intra-group bypass as REQ-020 (youngest earlier matching slot's disp_dest_pr), else the speculative map entry.
REQ-022 A map-sourced lookup SHALL report ready 1 if the stored ready bit is 1 or any valid CDB channel this cycle carries the same PR tag.
REQ-023 On a clock edge, each valid dispatch slot SHALL write disp_dest_pr into its AR with ready 0; for multiple slots on one AR the youngest wins.
REQ-024 On a clock edge, a valid CDB channel SHALL set ready for cdb_ar_tag only if that entry's current PR equals cdb_pr_tag; stale tags SHALL be ignored.
REQ-025 Dispatch write to an AR SHALL take priority over a same-cycle CDB set of that AR (result ready 0).
REQ-026 On a clock edge, each valid commit slot SHALL write commit_pr into the architectural map; youngest slot wins on AR conflict.
REQ-027 AR 2**AR_BITS-1 is the zero register: dispatch and commit writes to it SHALL be ignored; lookups SHALL return PR equal to that AR index, ready 1; told_pr for it SHALL be that same index.
REQ-028 With recover high, next speculative map SHALL equal the architectural map after applying the same cycle's commits, all ready bits 1; dispatch and CDB inputs that cycle SHALL be ignored.
REQ-029 recover SHALL take effect in one cycle; lookups in the following cycle SHALL see the restored map.
REQ-030 Back-to-back recover cycles SHALL each restore from the then-current architectural map.

Reset
REQ-031 While reset is high, both maps SHALL hold PR = AR index for every AR and all ready bits SHALL be 1, independent of clock.
REQ-032 Reset asserted mid-operation SHALL override dispatch, CDB, commit and recover immediately; first update after deassertion is the next rising edge.

Verification
REQ-033 Reset, then slot0 src_a AR 3 -> src_a_pr 3, ready 1; told_pr for dest AR 3 = 3.
REQ-034 Slot0 dest AR 4->PR 40, slot1 src_a AR 4, dest AR 4->PR 41 same cycle -> slot1 src_a_pr 40 ready 0, slot1 told_pr 40; next cycle AR 4 lookup -> 41 ready 0.
REQ-035 AR 4 mapped to 41; CDB ch2 AR 4/PR 41 -> same-cycle lookup ready 1, stored ready 1 next cycle; CDB AR 4/PR 40 -> ready stays 0.
REQ-036 Dispatch dest AR 5->PR 50 with CDB AR 5/PR 5 same cycle -> AR 5 maps 50, ready 0.
REQ-037 Commit AR 6->PR 60, speculative AR 6->PR 70 and AR 7->PR 71, then recover with commit AR 7->PR 72 same cycle -> next cycle AR 6=60, AR 7=72, both ready 1.
REQ-038 Dispatch dest AR 31->PR 99 -> AR 31 lookup still 31 ready 1; reset mid-recover -> all ARs map to own index.
